// File: rtl/wshb_if.sv
`default_nettype none
// wshb_if: classic Wishbone bus bundle with master/slave views; rev 1.0
interface wshb_if #(
    parameter int ADR_W = 32,
    parameter int DAT_W = 32
) ();
    logic [ADR_W-1:0]   adr;
    logic [DAT_W-1:0]   dat_ms;
    logic [DAT_W-1:0]   dat_sm;
    logic               we;
    logic [DAT_W/8-1:0] sel;
    logic [2:0]         cti;
    logic [1:0]         bte;
    logic               cyc;
    logic               stb;
    logic               ack;
    logic               err;
    logic               rty;

    modport master (
        output adr, dat_ms, we, sel, cti, bte, cyc, stb,
        input  dat_sm, ack, err, rty
    );

    modport slave (
        input  adr, dat_ms, we, sel, cti, bte, cyc, stb,
        output dat_sm, ack, err, rty
    );
endinterface
`default_nettype wire

// File: rtl/wshb_arbiter_2to1.sv
`default_nettype none
// wshb_arbiter_2to1: 2:1 Wishbone arbiter, registered grant, burst-limit hand-off; rev 1.0
// Define WSHB_ARB_ROUND_ROBIN_EN for round-robin tie-break from IDLE (default: master 0 wins).
module wshb_arbiter_2to1 #(
    parameter int MAX_BURST = 16
) (
    input  logic   clk,
    input  logic   rst_n,
    wshb_if.slave  wshb_ifs0,
    wshb_if.slave  wshb_ifs1,
    wshb_if.master wshb_ifm
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [7:0] BURST_MAX  = 8'(MAX_BURST);
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] burst_cnt;
    logic [7:0] burst_cnt_next;
    logic       req0;
    logic       req1;
    logic       burst_done;
    logic       tie_pick1;

    assign req0 = wshb_ifs0.cyc & wshb_ifs0.stb;
    assign req1 = wshb_ifs1.cyc & wshb_ifs1.stb;

    // The ack that completes the MAX_BURST-th transfer (or any later one once saturated).
    assign burst_done = wshb_ifm.ack && (burst_cnt >= BURST_LAST);

`ifdef WSHB_ARB_ROUND_ROBIN_EN
    logic last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 1'b1;
        end else if (state_next == GNT0 && state != GNT0) begin
            last <= 1'b0;
        end else if (state_next == GNT1 && state != GNT1) begin
            last <= 1'b1;
        end
    end

    assign tie_pick1 = ~last;
`else
    assign tie_pick1 = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            burst_cnt <= 8'd0;
        end else begin
            state     <= state_next;
            burst_cnt <= burst_cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    state_next = tie_pick1 ? GNT1 : GNT0;
                end else if (req0) begin
                    state_next = GNT0;
                end else if (req1) begin
                    state_next = GNT1;
                end
            end
            GNT0: begin
                if (!wshb_ifs0.cyc) begin
                    state_next = req1 ? GNT1 : IDLE;
                end else if (burst_done && req1) begin
                    state_next = GNT1;
                end
            end
            GNT1: begin
                if (!wshb_ifs1.cyc) begin
                    state_next = req0 ? GNT0 : IDLE;
                end else if (burst_done && req0) begin
                    state_next = GNT0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        burst_cnt_next = burst_cnt;
        if (state == IDLE || state_next != state) begin
            burst_cnt_next = 8'd0;
        end else if (wshb_ifm.ack && burst_cnt != BURST_MAX) begin
            burst_cnt_next = burst_cnt + 8'd1;
        end
    end

    // Read data is broadcast; only the granted master ever sees an ack qualify it.
    assign wshb_ifs0.dat_sm = wshb_ifm.dat_sm;
    assign wshb_ifs1.dat_sm = wshb_ifm.dat_sm;

    always_comb begin
        wshb_ifm.adr    = '0;
        wshb_ifm.dat_ms = '0;
        wshb_ifm.we     = 1'b0;
        wshb_ifm.sel    = '0;
        wshb_ifm.cti    = '0;
        wshb_ifm.bte    = '0;
        wshb_ifm.cyc    = 1'b0;
        wshb_ifm.stb    = 1'b0;
        wshb_ifs0.ack   = 1'b0;
        wshb_ifs0.err   = 1'b0;
        wshb_ifs0.rty   = 1'b0;
        wshb_ifs1.ack   = 1'b0;
        wshb_ifs1.err   = 1'b0;
        wshb_ifs1.rty   = 1'b0;
        case (state)
            GNT0: begin
                wshb_ifm.adr    = wshb_ifs0.adr;
                wshb_ifm.dat_ms = wshb_ifs0.dat_ms;
                wshb_ifm.we     = wshb_ifs0.we;
                wshb_ifm.sel    = wshb_ifs0.sel;
                wshb_ifm.cti    = wshb_ifs0.cti;
                wshb_ifm.bte    = wshb_ifs0.bte;
                wshb_ifm.cyc    = wshb_ifs0.cyc;
                wshb_ifm.stb    = wshb_ifs0.stb;
                wshb_ifs0.ack   = wshb_ifm.ack;
                wshb_ifs0.err   = wshb_ifm.err;
                wshb_ifs0.rty   = wshb_ifm.rty;
            end
            GNT1: begin
                wshb_ifm.adr    = wshb_ifs1.adr;
                wshb_ifm.dat_ms = wshb_ifs1.dat_ms;
                wshb_ifm.we     = wshb_ifs1.we;
                wshb_ifm.sel    = wshb_ifs1.sel;
                wshb_ifm.cti    = wshb_ifs1.cti;
                wshb_ifm.bte    = wshb_ifs1.bte;
                wshb_ifm.cyc    = wshb_ifs1.cyc;
                wshb_ifm.stb    = wshb_ifs1.stb;
                wshb_ifs1.ack   = wshb_ifm.ack;
                wshb_ifs1.err   = wshb_ifm.err;
                wshb_ifs1.rty   = wshb_ifm.rty;
            end
            default: ;
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_wshb_arbiter_2to1.sv
`default_nettype none
// tb_wshb_arbiter_2to1: directed self-checking bench for the 2:1 Wishbone arbiter; rev 1.0
module tb_wshb_arbiter_2to1;
    logic clk = 1'b0;
    logic rst_n;
    logic slv_en;

    always #5 clk = ~clk;

    wshb_if ifs0 ();
    wshb_if ifs1 ();
    wshb_if ifm ();

    // Slave: zero-wait-state acks while enabled; read data is a function of the address.
    assign ifm.ack    = ifm.cyc & ifm.stb & slv_en;
    assign ifm.dat_sm = ifm.adr ^ 32'hA5A5_0000;
    assign ifm.err    = 1'b0;
    assign ifm.rty    = 1'b0;

    wshb_arbiter_2to1 #(.MAX_BURST(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wshb_ifs0 (ifs0),
        .wshb_ifs1 (ifs1),
        .wshb_ifm  (ifm)
    );

    int          errors = 0;
    int          checks = 0;
    int          cyc_n  = 0;
    logic [31:0] m_adr  [2];
    int          m_left [2];
    int          m_acks [2];
    int          ack_owner [256];
    int          ack_cyc   [256];
    int          n_ack;
    int          exp_own [8];
    int          exp_len [8];
    int          win_exp [3];
    logic        s_cyc;
    logic [31:0] s_adr;
    logic        sa0;
    logic        sa1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int i);
        if (i == 0) begin
            ifs0.cyc    = (m_left[0] > 0);
            ifs0.stb    = (m_left[0] > 0);
            ifs0.adr    = m_adr[0];
            ifs0.dat_ms = ~m_adr[0];
            ifs0.we     = 1'b0;
            ifs0.sel    = 4'hF;
            ifs0.cti    = 3'd0;
            ifs0.bte    = 2'd0;
        end else begin
            ifs1.cyc    = (m_left[1] > 0);
            ifs1.stb    = (m_left[1] > 0);
            ifs1.adr    = m_adr[1];
            ifs1.dat_ms = m_adr[1] ^ 32'h0F0F_0F0F;
            ifs1.we     = 1'b1;
            ifs1.sel    = 4'hC;
            ifs1.cti    = 3'd0;
            ifs1.bte    = 2'd0;
        end
    endtask

    task automatic start(input int i, input logic [31:0] base, input int n);
        m_adr[i]  = base;
        m_left[i] = n;
        drive(i);
    endtask

    task automatic clear_log();
        n_ack  = 0;
        m_acks = '{0, 0};
    endtask

    // One bus cycle: sample/score at negedge, advance the master models after posedge.
    task automatic step();
        @(negedge clk);
        sa0   = ifs0.ack;
        sa1   = ifs1.ack;
        s_cyc = ifm.cyc;
        s_adr = ifm.adr;
        check("ack_route", 32'(sa0) + 32'(sa1), ifm.ack ? 32'd1 : 32'd0);
        if (sa0) begin
            check("m0_adr", ifm.adr, m_adr[0]);
            check("m0_dat_ms", ifm.dat_ms, ~m_adr[0]);
            check("m0_we", 32'(ifm.we), 32'd0);
            check("m0_dat_sm", ifs0.dat_sm, m_adr[0] ^ 32'hA5A5_0000);
        end
        if (sa1) begin
            check("m1_adr", ifm.adr, m_adr[1]);
            check("m1_dat_ms", ifm.dat_ms, m_adr[1] ^ 32'h0F0F_0F0F);
            check("m1_we_sel", {27'd0, ifm.we, ifm.sel}, 32'h1C);
            check("m1_dat_sm", ifs1.dat_sm, m_adr[1] ^ 32'hA5A5_0000);
        end
        if ((sa0 || sa1) && n_ack < 256) begin
            ack_owner[n_ack] = sa1 ? 1 : 0;
            ack_cyc[n_ack]   = cyc_n;
            n_ack++;
        end
        @(posedge clk);
        #1;
        cyc_n++;
        if (sa0 && m_left[0] > 0) begin
            m_left[0]--;
            m_acks[0]++;
            m_adr[0] += 32'd4;
            drive(0);
        end
        if (sa1 && m_left[1] > 0) begin
            m_left[1]--;
            m_acks[1]++;
            m_adr[1] += 32'd4;
            drive(1);
        end
    endtask

    task automatic run(input int max, input string tag);
        int k = 0;
        while ((m_left[0] > 0 || m_left[1] > 0) && k < max) begin
            step();
            k++;
        end
        check({tag, "_done"}, 32'(m_left[0] + m_left[1]), 32'd0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic check_runs(input string tag, input int nruns);
        int own [16];
        int len [16];
        int nr = 0;
        for (int k = 0; k < n_ack; k++) begin
            if (k == 0 || ack_owner[k] != ack_owner[k-1]) begin
                if (nr < 16) begin
                    own[nr] = ack_owner[k];
                    len[nr] = 0;
                end
                nr++;
            end
            if (nr <= 16) len[nr-1]++;
        end
        check({tag, "_nruns"}, 32'(nr), 32'(nruns));
        for (int r = 0; r < nruns && r < nr && r < 16; r++) begin
            check({tag, "_run_owner"}, 32'(own[r]), 32'(exp_own[r]));
            check({tag, "_run_len"}, 32'(len[r]), 32'(exp_len[r]));
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with both masters requesting and the slave willing to ack.
        rst_n  = 1'b0;
        slv_en = 1'b1;
        clear_log();
        start(0, 32'h1000_0000, 3);
        start(1, 32'h2000_0000, 2);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("rst_cyc", 32'(ifm.cyc), 32'd0);
            check("rst_stb_we", {30'd0, ifm.stb, ifm.we}, 32'd0);
            check("rst_acks", {30'd0, ifs0.ack, ifs1.ack}, 32'd0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rel_still_idle", 32'(ifm.cyc), 32'd0);
        step();
        check("rel_fwd_cyc", 32'(s_cyc), 32'd1);
        check("rel_fwd_adr", s_adr, 32'h1000_0000);
        check("rel_first_ack0", 32'(sa0), 32'd1);
        run(20, "t1");
        check("t1_acks0", 32'(m_acks[0]), 32'd3);
        check("t1_acks1", 32'(m_acks[1]), 32'd2);
        idle(3);

        // Single master 1: 40 writes at 0..156.
        clear_log();
        start(1, 32'h0000_0000, 40);
        run(60, "t2");
        check("t2_acks1", 32'(m_acks[1]), 32'd40);
        check("t2_acks0", 32'(m_acks[0]), 32'd0);
        check("t2_end_adr", m_adr[1], 32'd160);
        exp_own = '{1, 0, 0, 0, 0, 0, 0, 0};
        exp_len = '{40, 0, 0, 0, 0, 0, 0, 0};
        check_runs("t2", 1);
        idle(3);

        // Both request continuously: 16-ack blocks, then master 0 runs out.
        clear_log();
        start(0, 32'h1000_0000, 40);
        start(1, 32'h2000_0000, 40);
        run(200, "t3");
        check("t3_acks0", 32'(m_acks[0]), 32'd40);
        check("t3_acks1", 32'(m_acks[1]), 32'd40);
        exp_own = '{0, 1, 0, 1, 0, 1, 0, 0};
        exp_len = '{16, 16, 16, 16, 8, 8, 0, 0};
        check_runs("t3", 6);
        check("t3_no_bubble", 32'(ack_cyc[16] - ack_cyc[15]), 32'd1);
        idle(3);

        // Master 0 ends after 5 acks with master 1 waiting; counter restarts for master 1.
        clear_log();
        start(0, 32'h1100_0000, 5);
        step();
        start(1, 32'h2100_0000, 20);
        for (int k = 0; k < 20 && m_left[0] > 0; k++) step();
        step();
        start(0, 32'h1200_0000, 4);
        run(100, "t4");
        exp_own = '{0, 1, 0, 1, 0, 0, 0, 0};
        exp_len = '{5, 16, 4, 4, 0, 0, 0, 0};
        check_runs("t4", 4);
        check("t4_handoff_gap", 32'(ack_cyc[5] - ack_cyc[4]), 32'd2);
        idle(3);

        // Ties from IDLE separated by idle gaps; only the winner completes a transfer.
`ifdef WSHB_ARB_ROUND_ROBIN_EN
        win_exp = '{0, 1, 0};
`else
        win_exp = '{0, 0, 0};
`endif
        for (int t = 0; t < 3; t++) begin
            clear_log();
            start(0, 32'h1300_0000 + 32'(t * 16), 1);
            start(1, 32'h2300_0000 + 32'(t * 16), 1);
            for (int k = 0; k < 10 && n_ack == 0; k++) step();
            check("t5_tie_acked", 32'(n_ack), 32'd1);
            check("t5_tie_winner", 32'(ack_owner[0]), 32'(win_exp[t]));
            m_left = '{0, 0};
            drive(0);
            drive(1);
            idle(3);
        end

        // Reset mid-transfer with the slave stalling, then resume.
        clear_log();
        slv_en = 1'b0;
        start(1, 32'h2400_0000, 3);
        step();
        step();
        check("t6_fwd_cyc", 32'(s_cyc), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_cyc_stb", {30'd0, ifm.cyc, ifm.stb}, 32'd0);
        check("t6_rst_ack1", 32'(ifs1.ack), 32'd0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        slv_en = 1'b1;
        run(20, "t6");
        check("t6_acks1", 32'(m_acks[1]), 32'd3);
        check("t6_end_adr", m_adr[1], 32'h2400_000C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
